// File: rtl/rr_mux_sched4_if.sv
// rr_mux_sched4_if: source/consumer bundle for the round-robin mux scheduler
interface rr_mux_sched4_if #(parameter int WIDTH = 32);
    logic [3:0]       req;
    logic [3:0]       lock;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready;
    logic             locked;
    modport master (output req, lock, d0, d1, d2, d3, out_ready,
                    input gnt, out_data, out_src, out_valid, locked);
    modport slave  (input req, lock, d0, d1, d2, d3, out_ready,
                    output gnt, out_data, out_src, out_valid, locked);
endinterface

// File: rtl/rr_mux_sched4.sv
// rr_mux_sched4: round-robin 4:1 mux scheduler with locked bursts and a one-entry output register
module rr_mux_sched4 #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    rr_mux_sched4_if.slave bus
);
    typedef enum logic {ARB, LOCKED} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, ptr_nx, owner, owner_nx, win;
    logic cand, load;
    logic [WIDTH-1:0] sel;
    always_comb begin
        win = owner;
        cand = 1'b0;
        if (state == LOCKED) cand = bus.req[owner];
        else
            // descending scan so the nearest requester after ptr is assigned last
            for (int k = 4; k >= 1; k--)
                if (bus.req[ptr + 2'(k)]) begin
                    win = ptr + 2'(k);
                    cand = 1'b1;
                end
    end
    assign load = rst_n & cand & (!bus.out_valid | bus.out_ready);
    assign sel = win == 2'd0 ? bus.d0 : win == 2'd1 ? bus.d1 : win == 2'd2 ? bus.d2 : bus.d3;
    assign bus.gnt = load ? 4'(1) << win : 4'b0;
    assign bus.locked = state == LOCKED;
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx = load ? win : ptr;
        if (state == ARB) begin
            if (load && bus.lock[win]) begin
                state_nx = LOCKED;
                owner_nx = win;
            end
        end else if (!bus.req[owner]) begin
            state_nx = ARB;
            ptr_nx = owner;
        end else if (load && !bus.lock[owner]) state_nx = ARB;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ARB;
            ptr <= 2'd3;
            owner <= 2'd0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_src <= 2'd0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            owner <= owner_nx;
            bus.out_valid <= load | (bus.out_valid & !bus.out_ready);
            if (load) begin
                bus.out_data <= sel;
                bus.out_src <= win;
            end
        end
endmodule

// File: tb/tb_rr_mux_sched4.sv
// tb_rr_mux_sched4: vector table, corner sequences and random traffic against a reference model
module tb_rr_mux_sched4;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    rr_mux_sched4_if #(.WIDTH(32)) bus();
    rr_mux_sched4 #(.WIDTH(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    typedef struct {
        logic [3:0] req, lock;
        logic rdy;
        logic [3:0] gnt;
        logic [1:0] src;
        logic [31:0] data;
        logic v, lk;
    } vec_t;
    vec_t tbl[14];
    int total = 0, passed = 0;
    logic [31:0] dv[4];
    int mptr, mown, ms;
    bit mlk, mv;
    logic [31:0] md;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask
    task automatic model_reset();
        mptr = 3; mown = 0; ms = 0; mlk = 0; mv = 0; md = 0;
    endtask
    task automatic model_eval(output int w, output bit ld);
        w = -1;
        if (mlk) w = bus.req[mown] ? mown : -1;
        else for (int j = 1; j <= 4; j++) if (w < 0 && bus.req[(mptr + j) % 4]) w = (mptr + j) % 4;
        ld = (w >= 0) && (!mv || bus.out_ready);
    endtask
    task automatic model_edge(input int w, input bit ld);
        if (mlk && !bus.req[mown]) begin
            mlk = 0;
            mptr = mown;
        end else if (ld) begin
            md = dv[w]; ms = w; mptr = w;
            mlk = bus.lock[w];
            mown = w;
        end
        mv = ld || (mv && !bus.out_ready);
    endtask
    task automatic apply(input logic [3:0] r, input logic [3:0] l, input logic rdy, output logic [3:0] g);
        int w;
        bit ld;
        bus.req = r; bus.lock = l; bus.out_ready = rdy;
        bus.d0 = dv[0]; bus.d1 = dv[1]; bus.d2 = dv[2]; bus.d3 = dv[3];
        #1;
        model_eval(w, ld);
        g = bus.gnt;
        chk("gnt", g, ld ? 4'(1 << w) : 4'b0);
        chk("gnt_onehot", $onehot0(g), 1'b1);
        @(posedge clk);
        model_edge(w, ld);
        #1;
        chk("out_valid", bus.out_valid, mv);
        chk("out_data", bus.out_data, md);
        chk("out_src", bus.out_src, ms);
        chk("locked", bus.locked, mlk);
    endtask
    initial begin
        logic [3:0] g;
        tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0, 32'h100, 1'b1, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 32'h101, 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd1, 32'h101, 1'b1, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd1, 32'h101, 1'b1, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd1, 32'h101, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2, 32'h102, 1'b1, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 32'h103, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0, 32'h100, 1'b1, 1'b0};
        tbl[8]  = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 2'd1, 32'h101, 1'b1, 1'b1};
        tbl[9]  = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 2'd1, 32'h101, 1'b1, 1'b1};
        tbl[10] = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 2'd1, 32'h101, 1'b1, 1'b1};
        tbl[11] = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 32'h101, 1'b1, 1'b0};
        tbl[12] = '{4'b1010, 4'b0000, 1'b1, 4'b1000, 2'd3, 32'h103, 1'b1, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3, 32'h103, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) dv[i] = 32'h100 + 32'(i);
        bus.req = 4'b1111; bus.lock = 0; bus.out_ready = 1;
        bus.d0 = dv[0]; bus.d1 = dv[1]; bus.d2 = dv[2]; bus.d3 = dv[3];
        model_reset();
        #12;
        chk("rst_gnt", bus.gnt, 4'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 32'h0);
        chk("rst_src", bus.out_src, 2'd0);
        chk("rst_locked", bus.locked, 1'b0);
        bus.req = 0;
        #1 rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].req, tbl[i].lock, tbl[i].rdy, g);
            chk($sformatf("tbl%0d_gnt", i), g, tbl[i].gnt);
            chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].v);
            chk($sformatf("tbl%0d_src", i), bus.out_src, tbl[i].src);
            chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].data);
            chk($sformatf("tbl%0d_locked", i), bus.locked, tbl[i].lk);
        end
        dv[2] = 32'hDEADBEEF;
        apply(4'b0100, 4'b0000, 1'b1, g);
        chk("single_gnt", g, 4'b0100);
        chk("single_data", bus.out_data, 32'hDEADBEEF);
        chk("single_src", bus.out_src, 2'd2);
        apply(4'b0000, 4'b0000, 1'b1, g);
        chk("single_drain", bus.out_valid, 1'b0);
        apply(4'b0001, 4'b0001, 1'b1, g);
        apply(4'b0001, 4'b0001, 1'b1, g);
        chk("pre_rst_locked", bus.locked, 1'b1);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        #3 rst_n = 0;
        #1;
        model_reset();
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_locked", bus.locked, 1'b0);
        chk("midrst_gnt", bus.gnt, 4'b0);
        bus.req = 0;
        #1 rst_n = 1;
        @(posedge clk); #1;
        apply(4'b1000, 4'b0000, 1'b1, g);
        chk("midrst_gnt3", g, 4'b1000);
        chk("midrst_src3", bus.out_src, 2'd3);
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) dv[i] = $urandom;
            apply(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
                  1'($urandom_range(0, 3) != 0), g);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rr_mux_sched4.md
Name: rr_mux_sched4

Overview:
- Round-robin scheduler that shares a single WIDTH-bit 4-to-1 mux datapath among four requesters.
- Each cycle it picks one requesting source, steers the mux select to it, and captures the selected word into a one-entry output register with a valid/ready handshake.
- Supports optional locked bursts, so one source can keep ownership of the datapath.
- Sits between the four source ports and the downstream consumer; owns the mux select.

Parameters:
- WIDTH, 32, data width of each source and of the output word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  req[i] = source i has a word ready on d_i.
- lock  input  4  lock[i] = source i requests to keep ownership after its current grant; qualified by req[i].
- d0  input  WIDTH  source 0 data.
- d1  input  WIDTH  source 1 data.
- d2  input  WIDTH  source 2 data.
- d3  input  WIDTH  source 3 data.
- gnt  output  4  one-hot, combinational; gnt[i]=1 means d_i is captured at this edge and source i may advance.
- out_data  output  WIDTH  registered captured word.
- out_src  output  2  registered index of the source of out_data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- locked  output  1  registered; 1 while in LOCKED state.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_src=0, locked=0.
  - State=ARB; internal last-grant pointer=3, so source 0 has top priority first.
  - gnt=0 while in reset.
- Load condition: load = (!out_valid | out_ready) & (candidate exists).
  - gnt is non-zero only when load=1.
  - At most one gnt bit is ever set.
- Winner selection:
  - ARB: scan from (ptr+1) mod 4 upward, wrapping; the first i with req[i]=1 wins.
  - LOCKED: the only candidate is the owner, and only if req[owner]=1. Other requests are ignored.
- Mux select equals the winner index, combinationally from req, ptr, state and owner.
  - The selected d_i feeds the capture register.
- On a load edge: out_data<=d_winner, out_src<=winner, out_valid<=1, ptr<=winner.
  - Latency: a request granted at edge N appears on out_data after edge N.
  - Throughput is one word per cycle when out_ready stays 1.
- Output drain without reload: out_valid & out_ready & !load => out_valid<=0. out_data and out_src are held at their last value.
- Backpressure: out_valid=1 & out_ready=0 => gnt=0, and out_data, out_src and ptr are held.
- State machine:
  - ARB->LOCKED on a load edge when lock[winner]=1; owner<=winner, locked<=1.
  - LOCKED->LOCKED on a load edge with lock[owner]=1.
  - LOCKED->ARB on a load edge with lock[owner]=0: the final word of the burst is captured, then locked<=0.
  - LOCKED->ARB on any edge where req[owner]=0 (owner abandons); no capture that cycle, and ptr=owner so the next source is favoured.
- Simultaneous events:
  - A drain and a new load in the same cycle are both honoured: out_valid stays 1 with new data.
  - Any req change is sampled at the edge; no glitch requirements beyond a one-hot gnt.
- Fairness: in ARB with all four requesting continuously and out_ready=1, each source receives exactly one grant in every 4 consecutive grants.
- Reset mid-operation: asserting rst_n=0 at any point does the following immediately, without waiting for clk:
  - clears out_valid and locked;
  - forces gnt=0;
  - discards any pending word.
  - After release, arbitration restarts from source 0.
- Arithmetic: pointer increment is 2-bit modulo 4; there are no other counters.

Test Plan:
- Reset values: hold rst_n=0 with req=4'b1111 -> gnt=0, out_valid=0, out_data=0, out_src=0, locked=0. After release with out_ready=1, the first gnt=4'b0001 and out_src=0.
- Single source: req=4'b0100, d2=32'hDEADBEEF, out_ready=1 -> gnt=4'b0100 that cycle. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=2. Drop req -> out_valid=0 one cycle later.
- Round-robin: req=4'b1111, out_ready=1, d_i=i+32'h100 -> out_src sequence 0,1,2,3,0,1 and out_data 32'h100, 32'h101, 32'h102, 32'h103, ..., one per cycle.
- Backpressure: while out_valid=1 with out_data=32'h101, drop out_ready for 3 cycles -> gnt=0 and out_data stays 32'h101. Raise out_ready -> the next grant goes to source 2.
- Locked burst: req=4'b1010, lock[1]=1 for 3 grants then 0 -> out_src=1,1,1,1 with locked=1 during the burst. Then ARB resumes and the next grant is source 3.
- Reset mid-operation: in LOCKED with out_valid=1, pulse rst_n low between clock edges -> out_valid, locked and gnt drop immediately. After release with req=4'b1000, out_src=3.
